// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures the high time and period of an external pulse train in clkin
//   cycles. The pin is synchronized by two flops, and an edge register
//   follows them. A saturating counter times the phases. A four-state FSM
//   (IDLE/ARM/HIGH/LOW) discards the first period after arming and then
//   reports one measurement on every rising edge.
//
// Ports
//   clkin     : system clock
//   rst_n     : asynchronous active-low reset, clears all state
//   en        : measurement enable, 0 forces IDLE
//   pin_in    : raw asynchronous pulse input
//   high_time : cycles from a rising edge to the following falling edge
//   period    : cycles between consecutive rising edges
//   valid     : one-cycle pulse when high_time/period hold a new result
//   stuck     : no rising edge for 2^BITS-1 cycles while measuring
//   level     : synchronized pin level
module pwm_capture #(
    parameter int BITS = 16
) (
    input  logic            clkin,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pin_in,
    output logic [BITS-1:0] high_time,
    output logic [BITS-1:0] period,
    output logic            valid,
    output logic            stuck,
    output logic            level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [BITS-1:0] CNT_MAX = '1;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [BITS-1:0] sat_inc(input logic [BITS-1:0] v);
        if (v == CNT_MAX) return v;
        else              return v + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic            s1_q, s2_q, s3_q;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] hcap_q, hcap_d;
    logic [BITS-1:0] high_q, high_d;
    logic [BITS-1:0] per_q, per_d;
    logic            valid_q, valid_d;
    logic            stuck_q, stuck_d;

    logic rise, fall, sat;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;
    assign sat  = (cnt_q == CNT_MAX);

    // Counter: cleared outside measurement, restarted at 1 on each rise so
    // that the value seen at the next edge equals the elapsed cycle count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || state_q == IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = {{(BITS-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_comb begin
        state_d = state_q;
        hcap_d  = hcap_q;
        high_d  = high_q;
        per_d   = per_q;
        valid_d = 1'b0;
        stuck_d = stuck_q;
        if (!en) begin
            state_d = IDLE;
            stuck_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    // First rise only starts timing; it also clears stuck.
                    if (rise) begin
                        state_d = HIGH;
                        stuck_d = 1'b0;
                    end
                end
                HIGH: begin
                    if (sat) begin
                        stuck_d = 1'b1;
                        state_d = ARM;
                    end else if (fall) begin
                        hcap_d  = cnt_q;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    // A rise coinciding with saturation still completes
                    // the measurement.
                    if (rise) begin
                        per_d   = cnt_q;
                        high_d  = hcap_q;
                        valid_d = 1'b1;
                        state_d = HIGH;
                    end else if (sat) begin
                        stuck_d = 1'b1;
                        state_d = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            cnt_q   <= '0;
            hcap_q  <= '0;
            high_q  <= '0;
            per_q   <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= pin_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            hcap_q  <= hcap_d;
            high_q  <= high_d;
            per_q   <= per_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    assign high_time = high_q;
    assign period    = per_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign level     = s2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: a 16-bit and an 8-bit instance share the
// stimulus. A timestamp-based reference model predicts every output each
// cycle, and directed checks cover the scenarios of interest.
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic pin = 1'b0;

    logic [15:0] ht16, per16;
    logic [7:0]  ht8, per8;
    logic        v16, v8, st16, st8, lv16, lv8;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount16 = 0;

    always #5 clk = ~clk;

    pwm_capture #(.BITS(16)) dut16 (
        .clkin(clk), .rst_n(rst_n), .en(en), .pin_in(pin),
        .high_time(ht16), .period(per16), .valid(v16), .stuck(st16), .level(lv16)
    );

    pwm_capture #(.BITS(8)) dut8 (
        .clkin(clk), .rst_n(rst_n), .en(en), .pin_in(pin),
        .high_time(ht8), .period(per8), .valid(v8), .stuck(st8), .level(lv8)
    );

    // Reference model: measurement expressed as timestamps of detected edges.
    int   cyc = 0;
    logic d [3];            // pin samples delayed by 1, 2, 3 edges
    int   lim [2] = '{65535, 255};
    int   t0 [2];           // edge at which the current rise was consumed (-1: none)
    int   tf [2];           // edge at which the following fall was consumed (-1: none)
    bit   act [2];          // enable seen for at least one edge
    int   eht [2], eper [2];
    bit   evld [2], estk [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) d[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t0[k] = -1; tf[k] = -1; act[k] = 1'b0;
            eht[k] = 0; eper[k] = 0; evld[k] = 1'b0; estk[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic r, f;
        if (!rst_n) begin
            model_reset();
        end else begin
            r = d[1] & ~d[2];
            f = ~d[1] & d[2];
            for (int k = 0; k < 2; k++) begin
                evld[k] = 1'b0;
                if (!en) begin
                    act[k] = 1'b0; estk[k] = 1'b0; t0[k] = -1;
                end else if (!act[k]) begin
                    act[k] = 1'b1; t0[k] = -1;
                end else if (t0[k] < 0) begin
                    if (r) begin t0[k] = cyc; tf[k] = -1; estk[k] = 1'b0; end
                end else if (r && tf[k] >= 0) begin
                    eht[k] = tf[k] - t0[k]; eper[k] = cyc - t0[k]; evld[k] = 1'b1;
                    t0[k] = cyc; tf[k] = -1;
                end else if (cyc - t0[k] >= lim[k]) begin
                    estk[k] = 1'b1; t0[k] = -1;
                end else if (f && tf[k] < 0) begin
                    tf[k] = cyc;
                end
            end
            d[2] = d[1]; d[1] = d[0]; d[0] = pin;
        end
        cyc++;
    endtask

    task automatic compare_all();
        chk("ht16",  32'(ht16),  32'(eht[0]));
        chk("per16", 32'(per16), 32'(eper[0]));
        chk("vld16", 32'(v16),   32'(evld[0]));
        chk("stk16", 32'(st16),  32'(estk[0]));
        chk("lvl16", 32'(lv16),  32'(d[1]));
        chk("ht8",   32'(ht8),   32'(eht[1]));
        chk("per8",  32'(per8),  32'(eper[1]));
        chk("vld8",  32'(v8),    32'(evld[1]));
        chk("stk8",  32'(st8),   32'(estk[1]));
        chk("lvl8",  32'(lv8),   32'(d[1]));
    endtask

    task automatic step(input logic p);
        @(negedge clk);
        pin = p;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (v16) vcount16++;
    endtask

    task automatic pulses(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < h; j++) step(1'b1);
            for (int j = 0; j < l; j++) step(1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ht16"}, 32'(ht16), 32'd0);
        chk({tag, "_per16"}, 32'(per16), 32'd0);
        chk({tag, "_v16"}, 32'(v16), 32'd0);
        chk({tag, "_st8"}, 32'(st8), 32'd0);
        chk({tag, "_per8"}, 32'(per8), 32'd0);
        chk({tag, "_lv16"}, 32'(lv16), 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset with a toggling pin and enable high.
        for (int i = 0; i < 8; i++) step(i[0]);
        check_zero("rst");
        rst_n = 1'b1;
        // Enabled off: level tracks the pin, never a valid.
        en = 1'b0;
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)));
        // Steady 30/70, five periods: four valid pulses.
        en = 1'b1;
        vcount16 = 0;
        for (int i = 0; i < 5; i++) step(1'b0);
        pulses(30, 70, 5);
        chk("steady_vcount", 32'(vcount16), 32'd4);
        chk("steady_ht", 32'(ht16), 32'd30);
        chk("steady_per", 32'(per16), 32'd100);
        // Duty change to 60/40.
        pulses(60, 40, 3);
        chk("duty_ht", 32'(ht16), 32'd60);
        chk("duty_per", 32'(per16), 32'd100);
        // Random pulse widths.
        for (int i = 0; i < 25; i++)
            pulses(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
        // Minimum pulse 1/1.
        pulses(1, 1, 12);
        chk("min_ht", 32'(ht16), 32'd1);
        chk("min_per", 32'(per16), 32'd2);
        // Enable drop in the middle of a high phase.
        pulses(30, 70, 2);
        for (int i = 0; i < 15; i++) step(1'b1);
        en = 1'b0;
        step(1'b1);
        chk("endrop_vld", 32'(v16), 32'd0);
        chk("endrop_stk", 32'(st8), 32'd0);
        chk("endrop_ht", 32'(ht16), 32'd30);
        chk("endrop_per", 32'(per16), 32'd100);
        for (int i = 0; i < 4; i++) step(1'b1);
        en = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 70; i++) step(1'b0);
        pulses(30, 70, 3);
        // Stuck: one rise then held high.
        for (int i = 0; i < 300; i++) step(1'b1);
        chk("stuck8", 32'(st8), 32'd1);
        chk("nostuck16", 32'(st16), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0);
        pulses(10, 10, 4);
        chk("resume_stk", 32'(st8), 32'd0);
        chk("resume_ht", 32'(ht8), 32'd10);
        chk("resume_per", 32'(per8), 32'd20);
        // Asynchronous reset mid-stream.
        pulses(1, 1, 6);
        #2 rst_n = 1'b0;
        #1 check_zero("arst");
        step(1'b1);
        step(1'b0);
        rst_n = 1'b1;
        pulses(1, 1, 10);
        pulses(int'($urandom_range(2, 20)), int'($urandom_range(2, 20)), 4);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
